sram_mem_controller: RTL and testbench
======================================

SRAM_MEM_CONTROLLER -- requirements
Module: sram_mem_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait cycles per 16-bit half-access (legal 1..7).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rd_sram  input  1  read request from cache, held until stall drops.
REQ-005 SHALL have port wr_sram  input  1  write request from cache, held until stall drops.
REQ-006 SHALL have port addr_cpu  input  17  word address.
REQ-007 SHALL have port data_tosram  input  32  write data.
REQ-008 SHALL have port data_fromsram  output  32  read data, registered.
REQ-009 SHALL have port sram_stalled  output  1  high while a request is pending and not complete.
REQ-010 SHALL have port sram_addr  output  18  device address = {addr_cpu, half}.
REQ-011 SHALL have port sram_dq  inout  16  device data bus.
REQ-012 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n  output  1 each  device strobes, active-low.

Function
REQ-013 SHALL implement FSM IDLE -> ACC_LO -> ACC_HI -> DONE -> IDLE; each ACC state lasts WAIT_CYCLES+1 cycles, counted by a 3-bit wait counter.
REQ-014 SHALL, in IDLE with rd_sram|wr_sram, latch addr_cpu, data_tosram and op, then enter ACC_LO; wr_sram wins when both are high.
REQ-015 SHALL drive sram_stalled = (rd_sram|wr_sram) & (state != DONE), combinationally.
REQ-016 SHALL give latency: request first seen in cycle 0 -> DONE in cycle 2*WAIT_CYCLES+3, with sram_stalled low and data_fromsram valid in that cycle.
REQ-017 SHALL, in ACC_LO/ACC_HI, hold sram_addr = {latched addr, 0/1} and sram_ce_n=0 for the whole state.
REQ-018 SHALL, on reads, hold sram_oe_n=0 and capture sram_dq into data_fromsram[15:0] (LO) or [31:16] (HI) on the last cycle of the state.
REQ-019 SHALL, on writes, drive sram_dq with data[15:0]/[31:16] for the whole state and assert sram_we_n=0 in every cycle of the state except the first.
REQ-020 SHALL keep sram_dq high-Z and all strobes high in IDLE and DONE.
REQ-021 SHALL hold data_fromsram stable outside read captures.
REQ-022 SHALL complete a started transaction even if the request drops mid-access, then return to IDLE.
REQ-023 SHALL, when the request is still high in the cycle after DONE, treat it as a new request from IDLE.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state=IDLE, counter=0, data_fromsram=0, sram_addr=0, strobes high and sram_dq high-Z.
REQ-025 SHALL abandon any in-flight access on reset; no partial write completion is guaranteed.

Configuration
REQ-026 SHALL, with SRAM_CTRL_RDBUF_EN defined, keep a one-entry read buffer (valid, 17-bit addr, 32-bit data) that is filled at read DONE and cleared on reset.
REQ-027 SHALL, with SRAM_CTRL_RDBUF_EN, on a read hitting the valid buffer in IDLE, go straight to DONE next cycle with the buffer data and no device access.
REQ-028 SHALL, with SRAM_CTRL_RDBUF_EN, update the buffer data at DONE of a write to the buffered address.
REQ-029 SHALL, without SRAM_CTRL_RDBUF_EN, contain no buffer logic; every read accesses the device.

Structure
REQ-030 SHALL place the state enum and the SRAM_HALF_W=16 and SRAM_ADDR_W=18 constants in package sram_ctrl_pkg.
REQ-031 SHALL place the optional read buffer in sub-module sram_rdbuf.

Verification
REQ-032 Read 0x00A5 with WAIT_CYCLES=1, model returning 0x1234/0xABCD -> stall in cycles 0-4, data_fromsram=0xABCD1234 in cycle 5.
REQ-033 Write 0xDEADBEEF to 0x1FFFF -> sram_addr 0x3FFFE then 0x3FFFF, dq 0xBEEF then 0xDEAD, sram_we_n low 1 cycle per half.
REQ-034 rd_sram and wr_sram both high -> write performed, sram_oe_n never low.
REQ-035 rst_n low during ACC_HI of a write -> strobes high and dq high-Z in the same cycle; data_fromsram=0.
REQ-036 With SRAM_CTRL_RDBUF_EN, read 0x0010 twice -> second read completes in cycle 1 with sram_ce_n held high.
REQ-037 WAIT_CYCLES=3 read -> DONE in cycle 9; request dropped at cycle 4 -> access still runs to DONE.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM state, operation type and bus widths for the SRAM controller.
package sram_ctrl_pkg;
    localparam int SRAM_HALF_W = 16;
    localparam int SRAM_ADDR_W = 18;
    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/sram_rdbuf.sv
// sram_rdbuf: one-entry read buffer holding the last word read, kept coherent with writes.
// Present only when SRAM_CTRL_RDBUF_EN is defined.
`ifdef SRAM_CTRL_RDBUF_EN
module sram_rdbuf
    import sram_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [16:0]              lookup_addr,
    output logic                     hit,
    output logic [2*SRAM_HALF_W-1:0] hit_data,
    input  logic                     done_rd,
    input  logic                     done_wr,
    input  logic [16:0]              done_addr,
    input  logic [2*SRAM_HALF_W-1:0] rd_data,
    input  logic [2*SRAM_HALF_W-1:0] wr_data
);
    logic                     valid;
    logic [16:0]              tag;
    logic [2*SRAM_HALF_W-1:0] data;

    assign hit      = valid && tag == lookup_addr;
    assign hit_data = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (done_rd) begin
            valid <= 1'b1;
            tag   <= done_addr;
            data  <= rd_data;
        end else if (done_wr && valid && tag == done_addr) begin
            data  <= wr_data;
        end
    end
endmodule
`endif

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: 32-bit word access to a 16-bit async SRAM as two timed half-accesses.
// Define SRAM_CTRL_RDBUF_EN to add a one-entry read buffer that short-circuits repeat reads.
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_sram,
    input  logic                   wr_sram,
    input  logic [16:0]            addr_cpu,
    input  logic [31:0]            data_tosram,
    output logic [31:0]            data_fromsram,
    output logic                   sram_stalled,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [SRAM_HALF_W-1:0] sram_dq,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);
    state_t                 state;
    op_t                    op;
    logic [2:0]             cnt;
    logic [16:0]            addr_q;
    logic [31:0]            wdata_q;
    logic                   dq_oe;
    logic [SRAM_HALF_W-1:0] dq_out;
    logic                   last;
    logic                   buf_hit;
    logic [31:0]            buf_data;

    assign last         = cnt == 3'(WAIT_CYCLES);
    assign sram_stalled = (rd_sram | wr_sram) & (state != DONE);
    assign sram_dq      = dq_oe ? dq_out : 'z;

`ifdef SRAM_CTRL_RDBUF_EN
    sram_rdbuf u_rdbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (addr_cpu),
        .hit         (buf_hit),
        .hit_data    (buf_data),
        .done_rd     (state == DONE && op == OP_RD),
        .done_wr     (state == DONE && op == OP_WR),
        .done_addr   (addr_q),
        .rd_data     (data_fromsram),
        .wr_data     (wdata_q)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op            <= OP_RD;
            cnt           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            data_fromsram <= '0;
            sram_addr     <= '0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            dq_oe         <= 1'b0;
            dq_out        <= '0;
        end else begin
            case (state)
                IDLE: if (rd_sram | wr_sram) begin
                    addr_q  <= addr_cpu;
                    wdata_q <= data_tosram;
                    op      <= wr_sram ? OP_WR : OP_RD;
                    cnt     <= '0;
                    if (buf_hit && !wr_sram) begin
                        data_fromsram <= buf_data;
                        state         <= DONE;
                    end else begin
                        state     <= ACC_LO;
                        sram_addr <= {addr_cpu, 1'b0};
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= wr_sram;
                        sram_we_n <= 1'b1;
                        dq_oe     <= wr_sram;
                        dq_out    <= data_tosram[15:0];
                    end
                end
                ACC_LO: if (last) begin
                    if (op == OP_RD) data_fromsram[15:0] <= sram_dq;
                    state     <= ACC_HI;
                    cnt       <= '0;
                    sram_addr <= {addr_q, 1'b1};
                    sram_we_n <= 1'b1;
                    dq_out    <= wdata_q[31:16];
                end else begin
                    cnt       <= cnt + 3'd1;
                    sram_we_n <= op != OP_WR;
                end
                ACC_HI: if (last) begin
                    if (op == OP_RD) data_fromsram[31:16] <= sram_dq;
                    state     <= DONE;
                    cnt       <= '0;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    dq_oe     <= 1'b0;
                end else begin
                    cnt       <= cnt + 3'd1;
                    sram_we_n <= op != OP_WR;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: randomized and directed checks of two controllers (WAIT_CYCLES 1 and 3)
// against a word-level reference memory and behavioural SRAM devices.
module tb_sram_mem_controller;
    logic        clk;
    logic        rst_n;
    logic        rd [2];
    logic        wr [2];
    logic [16:0] addr [2];
    logic [31:0] din [2];
    logic [31:0] dout [2];
    logic        stall [2];
    logic [17:0] sa [2];
    logic        ce_n [2];
    logic        oe_n [2];
    logic        we_n [2];
    wire  [15:0] dq0;
    wire  [15:0] dq1;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [int];
`ifdef SRAM_CTRL_RDBUF_EN
    bit          bv [2];
    logic [16:0] ba [2];
`endif

    sram_mem_controller #(.WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_sram(rd[0]), .wr_sram(wr[0]), .addr_cpu(addr[0]),
        .data_tosram(din[0]), .data_fromsram(dout[0]), .sram_stalled(stall[0]), .sram_addr(sa[0]),
        .sram_dq(dq0), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0])
    );

    sram_mem_controller #(.WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_sram(rd[1]), .wr_sram(wr[1]), .addr_cpu(addr[1]),
        .data_tosram(din[1]), .data_fromsram(dout[1]), .sram_stalled(stall[1]), .sram_addr(sa[1]),
        .sram_dq(dq1), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1])
    );

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h2B5C};
    endfunction

    // Behavioural async SRAM devices: unwritten locations read back a fixed address pattern.
    bit          wrt0 [262144];
    bit          wrt1 [262144];
    logic [15:0] mem0 [262144];
    logic [15:0] mem1 [262144];
    assign dq0 = (!ce_n[0] && !oe_n[0]) ? (wrt0[sa[0]] ? mem0[sa[0]] : pat(sa[0])) : 16'bz;
    assign dq1 = (!ce_n[1] && !oe_n[1]) ? (wrt1[sa[1]] ? mem1[sa[1]] : pat(sa[1])) : 16'bz;
    always @(posedge clk) if (!ce_n[0] && !we_n[0]) begin mem0[sa[0]] <= dq0; wrt0[sa[0]] <= 1'b1; end
    always @(posedge clk) if (!ce_n[1] && !we_n[1]) begin mem1[sa[1]] <= dq1; wrt1[sa[1]] <= 1'b1; end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_rd(input int i, input logic [16:0] a);
        int k = i * 32'h20000 + int'(a);
        return ref_mem.exists(k) ? ref_mem[k] : {pat({a, 1'b1}), pat({a, 1'b0})};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int i, input int n);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // One cache transaction; drop_at >= 0 releases the request mid-access at that cycle.
    task automatic txn(input int i, input logic r, input logic w, input logic [16:0] a,
                       input logic [31:0] d, input int drop_at);
        int w_cyc, lat, k, ce_lo, we_lo, oe_wr, bad_dq, bad_addr;
        logic hit, half;
        logic [15:0] dqv;
        w_cyc = (i == 1) ? 3 : 1;
        hit = 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
        hit = r && !w && bv[i] && ba[i] == a;
`endif
        lat = hit ? 1 : 2 * w_cyc + 3;
        {ce_lo, we_lo, oe_wr, bad_dq, bad_addr} = '0;
        @(posedge clk);
        #1;
        rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
        k = 0;
        forever begin
            @(negedge clk);
            dqv = (i == 1) ? dq1 : dq0;
            half = ce_lo >= w_cyc + 1;
            if (!ce_n[i]) begin
                ce_lo++;
                if (sa[i] != {a, half}) bad_addr++;
            end
            if (!oe_n[i] && w) oe_wr++;
            if (!we_n[i]) begin
                we_lo++;
                if (dqv != (half ? d[31:16] : d[15:0])) bad_dq++;
            end
            if (drop_at >= 0 && k >= lat) break;
            if (drop_at < 0 && !stall[i]) break;
            if (k == 40) break;
            if (k == drop_at) begin rd[i] = 1'b0; wr[i] = 1'b0; end
            k++;
        end
        if (drop_at < 0) chk("latency", k, lat);
        else chk("done_strobes", {ce_n[i], oe_n[i], we_n[i]}, 3'b111);
        chk("ce_cycles", ce_lo, hit ? 0 : 2 * (w_cyc + 1));
        chk("addr_seq", bad_addr, 0);
        if (w) begin
            chk("we_cycles", we_lo, 2 * w_cyc);
            chk("oe_on_write", oe_wr, 0);
            chk("write_dq", bad_dq, 0);
            ref_mem[i * 32'h20000 + int'(a)] = d;
        end else begin
            chk("we_on_read", we_lo, 0);
            chk("read_data", dout[i], ref_rd(i, a));
`ifdef SRAM_CTRL_RDBUF_EN
            bv[i] = 1'b1;
            ba[i] = a;
`endif
        end
    endtask

    initial begin
        logic [16:0] pool [8];
        int v;
        pool = '{17'h0, 17'h1FFFF, 17'h10, 17'hA5, 17'h3C, 17'h1234, 17'h8000, 17'h0F0F};
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_strobes0", {ce_n[0], oe_n[0], we_n[0]}, 3'b111);
        chk("rst_dout0", dout[0], 32'h0);
        chk("rst_addr0", sa[0], 18'h0);
        chk("rst_stall0", stall[0], 1'b0);
        chk("rst_strobes1", {ce_n[1], oe_n[1], we_n[1]}, 3'b111);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Write then read back a known word; then an upper-edge address write.
        txn(0, 1'b0, 1'b1, 17'h00A5, 32'hABCD1234, -1);
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 17'h00A5, 32'h0, -1);
        idle(0, 2);
        txn(0, 1'b0, 1'b1, 17'h1FFFF, 32'hDEADBEEF, -1);
        txn(0, 1'b1, 1'b0, 17'h1FFFF, 32'h0, -1);
        idle(0, 1);
        // Simultaneous read and write: the write wins.
        txn(0, 1'b1, 1'b1, 17'h0100, 32'h5A5AC3C3, -1);
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 17'h0100, 32'h0, -1);
        idle(0, 1);
        // Repeated read of the same word (buffer hit when the read buffer is built in).
        txn(0, 1'b1, 1'b0, 17'h0010, 32'h0, -1);
        txn(0, 1'b1, 1'b0, 17'h0010, 32'h0, -1);
        idle(0, 1);

        for (int n = 0; n < 24; n++) begin
            v = $urandom_range(0, 3);
            txn(0, v != 2, v >= 2, pool[$urandom_range(0, 7)], $urandom, -1);
            if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(0, 2));
        end
        idle(0, 1);

        // Slower device: full-length read, then a read whose request drops mid-access.
        txn(1, 1'b1, 1'b0, 17'h0321, 32'h0, -1);
        idle(1, 1);
        txn(1, 1'b0, 1'b1, 17'h0777, 32'h13579BDF, -1);
        idle(1, 1);
        txn(1, 1'b1, 1'b0, 17'h0777, 32'h0, 4);
        idle(1, 1);

        // Reset during the high half of a write.
        @(posedge clk);
        #1;
        wr[0] = 1'b1; addr[0] = 17'h0BEEF; din[0] = 32'hCAFEF00D;
        repeat (4) @(negedge clk);
        chk("pre_reset_ce", ce_n[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", {ce_n[0], oe_n[0], we_n[0]}, 3'b111);
        chk("midrst_dout", dout[0], 32'h0);
        chk("midrst_addr", sa[0], 18'h0);
        wr[0] = 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
        bv[0] = 1'b0;
        bv[1] = 1'b0;
`endif
        @(negedge clk) rst_n = 1'b1;
        txn(0, 1'b1, 1'b0, 17'h00A5, 32'h0, -1);
        idle(0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
